// File: rtl/arith_defs.sv
// Shared arithmetic definitions: serial-unit FSM encodings and default datapath width.
package arith_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int ARITH_W = 4;

  // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/sub_1.sv
// Combinational one-bit full subtractor: diff = ina - inb - bin, bout = borrow out.
module sub_1 (
  input  logic ina,
  input  logic inb,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = ina ^ inb ^ bin;
  assign bout = (~ina & inb) | (~ina & bin) | (inb & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial ripple-borrow subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, W clocks per operation, start/ready/done handshake.
module sub_serial
  import arith_defs::*;
#(
  parameter int W = ARITH_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         bin,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout
);

  localparam int            CW       = cnt_width(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t        state_reg;
  logic [W-1:0]  a_sh_reg;
  logic [W-1:0]  b_sh_reg;
  logic [W-1:0]  res_reg;
  logic          brw_reg;
  logic [CW-1:0] cnt_reg;
  logic          ready_reg;
  logic          done_reg;
  logic [W-1:0]  diff_reg;
  logic          bout_reg;

  logic          d_bit;
  logic          brw_next;
  logic [W-1:0]  res_next;

  sub_1 u_cell (
    .ina  (a_sh_reg[0]),
    .inb  (b_sh_reg[0]),
    .bin  (brw_reg),
    .diff (d_bit),
    .bout (brw_next)
  );

  // Each new difference bit enters at the MSB so the LSB lands at bit 0 after W shifts.
  always_comb begin
    res_next = (res_reg >> 1) | (W'(d_bit) << (W - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      res_reg   <= '0;
      brw_reg   <= 1'b0;
      cnt_reg   <= '0;
      ready_reg <= 1'b1;
      done_reg  <= 1'b0;
      diff_reg  <= '0;
      bout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_sh_reg  <= in_a;
            b_sh_reg  <= in_b;
            brw_reg   <= bin;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
            state_reg <= ST_RUN;
          end else begin
            ready_reg <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh_reg <= a_sh_reg >> 1;
          b_sh_reg <= b_sh_reg >> 1;
          res_reg  <= res_next;
          brw_reg  <= brw_next;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            diff_reg  <= res_next;
            bout_reg  <= brw_next;
            done_reg  <= 1'b1;
            ready_reg <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        default: begin
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready = ready_reg;
  assign done  = done_reg;
  assign diff  = diff_reg;
  assign bout  = bout_reg;

endmodule
